// File: rtl/prio_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : prio_encoder_pipe
//  Description : Registered N-to-log2(N) priority encoder with valid/ready
//                handshake, selectable LSB/MSB/round-robin/one-hot modes and
//                a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder_pipe #(
    parameter int N     = 16,
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_req,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_index,
    output logic             out_any,
    output logic             out_multi,
    output logic             out_error,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] c_mode_lsb = 2'd0;
    localparam logic [1:0] c_mode_msb = 2'd1;
    localparam logic [1:0] c_mode_rr  = 2'd2;
    localparam logic [1:0] c_mode_oh  = 2'd3;

    logic             r_out_valid;
    logic [W-1:0]     r_out_index;
    logic             r_out_any;
    logic             r_out_multi;
    logic             r_out_error;
    logic [CNT_W-1:0] r_err_count;
    logic [W-1:0]     r_rr_ptr;

    logic             w_accept;
    logic [W-1:0]     w_lsb_idx;
    logic             w_lsb_hit;
    logic [W-1:0]     w_msb_idx;
    logic [W-1:0]     w_rr_idx;
    logic             w_rr_hit;
    logic [W-1:0]     w_pos;
    logic             w_any;
    logic             w_multi;
    logic             w_onehot;
    logic [W-1:0]     w_index;
    logic             w_error;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_any    = |in_req;
    assign w_multi  = |(in_req & (in_req - N'(1)));
    assign w_onehot = w_any && !w_multi;

    always_comb begin
        w_lsb_idx = '0;
        w_lsb_hit = 1'b0;
        w_msb_idx = '0;
        w_rr_idx  = '0;
        w_rr_hit  = 1'b0;
        w_pos     = '0;
        for (int i = 0; i < N; i++) begin
            if (in_req[i] && !w_lsb_hit) begin
                w_lsb_idx = W'(i);
                w_lsb_hit = 1'b1;
            end
            if (in_req[i]) begin
                w_msb_idx = W'(i);
            end
        end
        // N is a power of two, so the W-bit add wraps from N-1 back to 0.
        for (int k = 0; k < N; k++) begin
            w_pos = r_rr_ptr + W'(k);
            if (in_req[w_pos] && !w_rr_hit) begin
                w_rr_idx = w_pos;
                w_rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_index = '0;
        w_error = 1'b0;
        case (in_mode)
            c_mode_lsb: w_index = w_lsb_idx;
            c_mode_msb: w_index = w_msb_idx;
            c_mode_rr:  w_index = w_rr_idx;
            c_mode_oh: begin
                w_index = w_onehot ? w_lsb_idx : '0;
                w_error = !w_onehot;
            end
            default: w_index = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_any   <= 1'b0;
            r_out_multi <= 1'b0;
            r_out_error <= 1'b0;
            r_err_count <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_index <= w_index;
                r_out_any   <= w_any;
                r_out_multi <= w_multi;
                r_out_error <= w_error;
                if (w_error && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
                if ((in_mode == c_mode_rr) && w_any) begin
                    r_rr_ptr <= w_rr_idx + W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_any   = r_out_any;
    assign out_multi = r_out_multi;
    assign out_error = r_out_error;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_encoder_pipe
//  Description : Directed bench for prio_encoder_pipe (default instance plus
//                a CNT_W=2 instance driven by the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_in_valid;
    logic [15:0] r_in_req;
    logic [1:0]  r_in_mode;
    logic        r_out_ready;

    logic        w_in_ready,  w_out_valid,  w_out_any,  w_out_multi,  w_out_error;
    logic [3:0]  w_out_index;
    logic [7:0]  w_err_count;
    logic        w2_in_ready, w2_out_valid, w2_out_any, w2_out_multi, w2_out_error;
    logic [3:0]  w2_out_index;
    logic [1:0]  w2_err_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    prio_encoder_pipe #(.N(16), .W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(rst), .in_valid(r_in_valid), .in_ready(w_in_ready),
        .in_req(r_in_req), .in_mode(r_in_mode), .out_valid(w_out_valid),
        .out_ready(r_out_ready), .out_index(w_out_index), .out_any(w_out_any),
        .out_multi(w_out_multi), .out_error(w_out_error), .err_count(w_err_count)
    );

    prio_encoder_pipe #(.N(16), .W(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(rst), .in_valid(r_in_valid), .in_ready(w2_in_ready),
        .in_req(r_in_req), .in_mode(r_in_mode), .out_valid(w2_out_valid),
        .out_ready(r_out_ready), .out_index(w2_out_index), .out_any(w2_out_any),
        .out_multi(w2_out_multi), .out_error(w2_out_error), .err_count(w2_err_count)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] req;
        logic [3:0]  idx;
        logic        any;
        logic        multi;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        r_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] mode, input logic [15:0] req);
        r_in_valid  = 1'b1;
        r_in_mode   = mode;
        r_in_req    = req;
        r_out_ready = 1'b1;
        tick();
        r_in_valid = 1'b0;
    endtask

    task automatic chk_result(input string name, input vec_t v);
        chk({name, ".valid"}, w_out_valid, 1);
        chk({name, ".index"}, w_out_index, v.idx);
        chk({name, ".any"},   w_out_any,   v.any);
        chk({name, ".multi"}, w_out_multi, v.multi);
        chk({name, ".error"}, w_out_error, v.err);
    endtask

    vec_t vecs[$];
    vec_t v;
    logic [3:0] rr_exp[4];

    initial begin
        rst = 1'b1; r_in_valid = 1'b0; r_in_req = '0; r_in_mode = '0; r_out_ready = 1'b1;
        vecs.push_back('{2'd0, 16'h0110, 4'd4,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{2'd1, 16'h0110, 4'd8,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{2'd0, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 16'h0001, 4'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{2'd1, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{2'd0, 16'hF0F0, 4'd4,  1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 16; i++) begin
            v.mode = 2'd3; v.req = 16'h1 << i; v.idx = 4'(i);
            v.any = 1'b1; v.multi = 1'b0; v.err = 1'b0;
            vecs.push_back(v);
        end
        vecs.push_back('{2'd3, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{2'd3, 16'h0003, 4'd0, 1'b1, 1'b1, 1'b1});

        do_reset();
        chk("reset.valid", w_out_valid, 0);
        chk("reset.index", w_out_index, 0);
        chk("reset.flags", {w_out_any, w_out_multi, w_out_error}, 0);
        chk("reset.err_count", w_err_count, 0);
        chk("reset.in_ready", w_in_ready, 1);

        // Back-to-back stream through the table.
        r_out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            r_in_valid = 1'b1;
            r_in_mode  = vecs[i].mode;
            r_in_req   = vecs[i].req;
            tick();
            chk_result($sformatf("vec%0d", i), vecs[i]);
        end
        r_in_valid = 1'b0;
        chk("table.err_count", w_err_count, 2);
        chk("table.err_count_w2", w2_err_count, 2);
        tick();
        chk("idle.valid", w_out_valid, 0);
        chk("idle.hold_index", w_out_index, 0);
        chk("idle.hold_error", w_out_error, 1);

        // Round-robin with rr_ptr starting at 0.
        rr_exp = '{4'd0, 4'd8, 4'd15, 4'd0};
        for (int i = 0; i < 4; i++) begin
            send(2'd2, 16'h8101);
            chk($sformatf("rr%0d.index", i), w_out_index, rr_exp[i]);
            chk($sformatf("rr%0d.multi", i), w_out_multi, 1);
        end
        send(2'd2, 16'h0003);
        chk("rr.wrap_ptr1", w_out_index, 1);

        // Backpressure: hold result for five cycles with a new input waiting.
        send(2'd0, 16'h0040);
        chk("bp.first", w_out_index, 6);
        r_out_ready = 1'b0;
        r_in_valid  = 1'b1;
        r_in_mode   = 2'd0;
        r_in_req    = 16'h0200;
        #1;
        chk("bp.in_ready_low", w_in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp.hold%0d.valid", i), w_out_valid, 1);
            chk($sformatf("bp.hold%0d.index", i), w_out_index, 6);
            chk($sformatf("bp.hold%0d.in_ready", i), w_in_ready, 0);
        end
        r_out_ready = 1'b1;
        #1;
        chk("bp.in_ready_release", w_in_ready, 1);
        tick();
        r_in_valid = 1'b0;
        chk("bp.new.valid", w_out_valid, 1);
        chk("bp.new.index", w_out_index, 9);
        tick();
        chk("bp.drain.valid", w_out_valid, 0);
        chk("bp.drain.hold", w_out_index, 9);

        // Saturation of the 2-bit counter.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(2'd3, 16'h0000);
            chk($sformatf("sat%0d.err_w2", i), w2_err_count, (i < 3) ? i + 1 : 3);
            chk($sformatf("sat%0d.err_w8", i), w_err_count, i + 1);
        end

        // Reset mid-operation with rr_ptr=5 and err_count=2.
        do_reset();
        send(2'd2, 16'h0010);
        chk("rst.setup_rr", w_out_index, 4);
        send(2'd3, 16'h0000);
        send(2'd3, 16'h0000);
        chk("rst.setup_err", w_err_count, 2);
        r_in_valid = 1'b1; r_in_mode = 2'd3; r_in_req = 16'h0000; r_out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst.in_ready_during", w_in_ready, 1);
        tick();
        rst = 1'b0;
        r_in_valid = 1'b0;
        chk("rst.valid", w_out_valid, 0);
        chk("rst.index", w_out_index, 0);
        chk("rst.flags", {w_out_any, w_out_multi, w_out_error}, 0);
        chk("rst.err_count", w_err_count, 0);
        send(2'd2, 16'h0021);
        chk("rst.rr_ptr_zero", w_out_index, 0);
        chk("rst.err_after", w_err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
